// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core front end.
//   ifetch_state_t   : fetch controller sequencing states
//   INST_BYTES       : size of one instruction word, the sequential PC step
//   DEFAULT_RESET_PC : fetch address loaded on reset unless overridden
// ----------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [2:0] {
      FETCH,
      WAIT,
      HOLD,
      DRAIN,
      ERR
   } ifetch_state_t;

   localparam logic [31:0] INST_BYTES       = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : core_pkg

// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl
// Owns the program counter and sequences single-outstanding instruction
// fetches. Fetched words are held for decode until accepted; taken
// branch/jump redirects from execute replace the PC and discard any
// wrong-path instruction, whether in flight or already held.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   imem_req/addr     : fetch request and address (address = fetch PC)
//   imem_gnt          : memory accepted the request
//   imem_rvalid/rdata : read response, instruction word
//   redirect_valid    : execute resolved a taken branch/jump
//   redirect_target   : new PC
//   inst_valid/ready  : decode handshake
//   inst, inst_pc     : held instruction word and its address
//   misalign_err      : sticky, a redirect target was not word aligned
// ----------------------------------------------------------------------------
module ifetch_ctrl
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   ifetch_state_t state_reg;
   logic [31:0]   fetch_pc_reg;
   logic [31:0]   inst_reg;
   logic [31:0]   inst_pc_reg;
   logic          inst_valid_reg;
   logic          misalign_reg;

   // Request is a decode of registered state; gating with reset keeps the
   // bus quiet for the whole reset cycle even before the state is reloaded.
   assign imem_req     = (state_reg == FETCH) && !reset;
   assign imem_addr    = fetch_pc_reg;
   assign inst_valid   = inst_valid_reg;
   assign inst         = inst_reg;
   assign inst_pc      = inst_pc_reg;
   assign misalign_err = misalign_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= FETCH;
         fetch_pc_reg   <= RESET_PC;
         inst_reg       <= '0;
         inst_pc_reg    <= '0;
         inst_valid_reg <= 1'b0;
         misalign_reg   <= 1'b0;
      end else if (state_reg == ERR) begin
         // Terminal until reset: redirects and responses are ignored.
         state_reg <= ERR;
      end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
         state_reg      <= ERR;
         misalign_reg   <= 1'b1;
         inst_valid_reg <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect wins over every normal transition. Any request that is
         // granted but not yet answered belongs to the old path, so its
         // response must be swallowed in DRAIN before fetching again.
         fetch_pc_reg   <= redirect_target;
         inst_valid_reg <= 1'b0;
         unique case (state_reg)
            FETCH:   state_reg <= imem_gnt    ? DRAIN : FETCH;
            WAIT:    state_reg <= imem_rvalid ? FETCH : DRAIN;
            HOLD:    state_reg <= FETCH;
            DRAIN:   state_reg <= imem_rvalid ? FETCH : DRAIN;
            default: state_reg <= ERR;
         endcase
      end else begin
         unique case (state_reg)
            FETCH: begin
               if (imem_gnt) begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  inst_reg       <= imem_rdata;
                  inst_pc_reg    <= fetch_pc_reg;
                  inst_valid_reg <= 1'b1;
                  fetch_pc_reg   <= fetch_pc_reg + INST_BYTES;
                  state_reg      <= HOLD;
               end
            end
            HOLD: begin
               if (inst_valid_reg && inst_ready) begin
                  inst_valid_reg <= 1'b0;
                  state_reg      <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_rvalid) begin
                  state_reg <= FETCH;
               end
            end
            default: state_reg <= ERR;
         endcase
      end
   end

   // A response with no request outstanding means the memory side broke
   // the handshake.
   rvalid_only_when_outstanding : assert property (
      @(posedge clk) disable iff (reset)
      !(imem_rvalid && ((state_reg == FETCH) || (state_reg == HOLD)))
   );

endmodule : ifetch_ctrl

// File: tb/tb_ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifetch_ctrl
// Drives ifetch_ctrl with directed scenarios followed by random traffic from a
// small memory model, and compares every output each cycle against a
// transaction-level reference (PC, outstanding request, held instruction).
// A second instance with an overridden reset PC covers PC wrap-around.
// ----------------------------------------------------------------------------
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign_err;

   ifetch_ctrl u_dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .misalign_err    (misalign_err)
   );

   logic        w_reset = 1'b1;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_gnt = 1'b0;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata = '0;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_err;

   ifetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk             (clk),
      .reset           (w_reset),
      .imem_req        (w_req),
      .imem_addr       (w_addr),
      .imem_gnt        (w_gnt),
      .imem_rvalid     (w_rvalid),
      .imem_rdata      (w_rdata),
      .redirect_valid  (1'b0),
      .redirect_target (32'h0),
      .inst_valid      (w_valid),
      .inst_ready      (w_ready),
      .inst            (w_inst),
      .inst_pc         (w_inst_pc),
      .misalign_err    (w_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: fetch PC, whether a granted request is awaiting its
   // response (and whether that response is wrong-path), the held
   // instruction, and the sticky error. The bus requests exactly when nothing
   // is outstanding, nothing is held and no error occurred.
   bit          m_rst, m_err, m_out, m_stale, m_held;
   logic [31:0] m_pc, m_inst, m_ipc;

   task automatic model_reset();
      m_err = 0; m_out = 0; m_stale = 0; m_held = 0;
      m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
   endtask

   function automatic bit model_can_req();
      return !m_err && !m_held && !m_out;
   endfunction

   // One clock: compare the current outputs, drive new inputs, advance model.
   task automatic step(input bit rst, input bit g, input bit rv, input logic [31:0] rd,
                       input bit rdy, input bit rdv, input logic [31:0] tgt);
      bit acc, resp;
      @(negedge clk);
      check_val("imem_req", imem_req, !m_rst && model_can_req());
      check_val("imem_addr", imem_addr, m_pc);
      check_val("inst_valid", inst_valid, m_held);
      check_val("inst", inst, m_inst);
      check_val("inst_pc", inst_pc, m_ipc);
      check_val("misalign_err", misalign_err, m_err);
      reset = rst; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
      inst_ready = rdy; redirect_valid = rdv; redirect_target = tgt;
      if (rst) begin
         model_reset();
      end else if (!m_err) begin
         acc  = model_can_req() && g;
         resp = m_out && rv;
         if (rdv && tgt[1:0] != 2'b00) begin
            m_err = 1; m_held = 0; m_out = 0; m_stale = 0;
         end else if (rdv) begin
            m_pc   = tgt;
            m_held = 0;
            m_out  = (m_out && !resp) || acc;
            m_stale = m_out;
         end else begin
            if (m_held && rdy) m_held = 0;
            if (resp) begin
               m_out = 0;
               if (!m_stale) begin
                  m_held = 1; m_inst = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
               end
            end
            if (acc) begin
               m_out = 1; m_stale = 0;
            end
         end
      end
      m_rst = rst;
   endtask

   bit          mem_pend;
   int          mem_cnt;
   bit          r_rst, r_g, r_rv, r_rdy, r_rdv, acc_pred;
   logic [31:0] r_tgt;

   initial begin
      model_reset();
      m_rst = 1;

      // Reset held for two cycles.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);

      // Zero-wait-state fetches: 0x0, 0x4, 0x8.
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 1, 0, 0);
         step(0, 0, 1, 32'h1000_0000 + i, 1, 0, 0);
         step(0, 0, 0, 0, 1, 0, 0);
      end

      // Decode back-pressure for 5 cycles in HOLD, then one transfer.
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'hCAFE_0001, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Redirect to 0x100 while waiting; stale 0xDEADBEEF arrives 3 cycles later.
      step(0, 1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h100);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0);
      step(0, 0, 1, 32'h0000_0100, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);

      // Redirect to 0x40 in the same cycle as the grant.
      step(0, 1, 0, 0, 1, 1, 32'h40);
      step(0, 0, 1, 32'h5A5A_5A5A, 1, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0);
      step(0, 0, 1, 32'h0000_0040, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);

      // Misaligned redirect, later aligned redirect ignored, reset clears.
      step(0, 0, 0, 0, 1, 1, 32'h102);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1, 1, 32'h200);
      step(0, 1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0);

      // Random traffic against the model with a simple memory responder.
      mem_pend = 0;
      mem_cnt  = 0;
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 63) == 0);
         r_g   = ($urandom_range(0, 2) != 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rdv = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 7))
            0:       r_tgt = 32'hFFFF_FFFC;
            1:       r_tgt = {$urandom()} | 32'h1;
            default: r_tgt = {$urandom()} & 32'hFFFF_FFFC;
         endcase
         r_rv = mem_pend && (mem_cnt == 0);
         if (mem_pend && mem_cnt != 0) mem_cnt--;
         acc_pred = !r_rst && model_can_req() && r_g;
         step(r_rst, r_g, r_rv, $urandom(), r_rdy, r_rdv, r_tgt);
         if (r_rv) mem_pend = 0;
         if (r_rst) begin
            mem_pend = 0;
         end else if (acc_pred) begin
            mem_pend = 1;
            mem_cnt  = $urandom_range(0, 3);
         end
      end
      step(1, 0, 0, 0, 0, 0, 0);

      // Reset PC override: 0xFFFF_FFFC wraps to 0x0000_0000.
      @(negedge clk);
      check_val("wrap_req_in_reset", w_req, 1'b0);
      w_reset = 1'b0;
      w_gnt   = 1'b1;
      #1;
      check_val("wrap_req", w_req, 1'b1);
      check_val("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      w_gnt    = 1'b0;
      w_rvalid = 1'b1;
      w_rdata  = 32'h0000_0013;
      @(negedge clk);
      w_rvalid = 1'b0;
      check_val("wrap_valid", w_valid, 1'b1);
      check_val("wrap_inst", w_inst, 32'h0000_0013);
      check_val("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
      w_ready = 1'b1;
      @(negedge clk);
      w_ready = 1'b0;
      check_val("wrap_next_req", w_req, 1'b1);
      check_val("wrap_next_addr", w_addr, 32'h0000_0000);
      check_val("wrap_err", w_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_ifetch_ctrl

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that owns the program counter and sequences instruction fetches for the RISC-V core. It issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake and presents fetched instructions to decode over a valid/ready handshake. It applies branch/jump redirects from execute, discarding any in-flight or held wrong-path instruction. It replaces the free-running PC+4/PC+offset register once memory latency and decode back-pressure exist.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high; forces the reset state below
- imem_req  out  1  fetch request, asserted only in FETCH
- imem_addr  out  32  fetch address; equals fetch_pc
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  read data valid, at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  execute resolved a taken branch/jump
- redirect_target  in  32  new PC, already PC+offset
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts the instruction
- inst  out  32  held instruction word
- inst_pc  out  32  address of inst
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- States: FETCH, WAIT, HOLD, DRAIN, ERR.
- FETCH: imem_req=1 with imem_addr=fetch_pc. On gnt, go to WAIT.
- WAIT: on rvalid, register inst<=rdata and inst_pc<=fetch_pc, set inst_valid=1, set fetch_pc<=fetch_pc+4, and go to HOLD.
- HOLD: inst, inst_pc and inst_valid stay stable until inst_valid&&inst_ready. On acceptance, clear inst_valid and go to FETCH.
- DRAIN: waits for the one stale rvalid, discards its data, then goes to FETCH. imem_req=0 in this state.
- ERR: imem_req=0, inst_valid=0, misalign_err=1. The block stays here until reset; redirects are ignored.
- A redirect with target[1:0]==0 has priority over every normal transition. It sets fetch_pc<=redirect_target and clears inst_valid, and the next state depends on the current one:
  - FETCH without gnt: stays in FETCH.
  - FETCH with gnt: goes to DRAIN, because the granted request belongs to the wrong path.
  - WAIT without rvalid: goes to DRAIN.
  - WAIT with rvalid: the data is dropped and the block goes to FETCH.
  - HOLD: the held instruction is dropped, even if inst_ready was high in the same cycle, and the block goes to FETCH.
  - DRAIN: stays in DRAIN. If rvalid arrives that cycle, the block goes to FETCH.
- A redirect with target[1:0]!=0 goes to ERR from any state. If a request is outstanding, its response is ignored.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
- rvalid arriving in FETCH or HOLD is a protocol violation and is ignored. An assertion flags it in simulation.

## Timing
- Reset values: state=FETCH, fetch_pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, misalign_err=0.
- imem_req is forced to 0 during any cycle with reset=1. It rises in the first cycle after reset is released.
- imem_req and imem_addr are combinational decodes of registered state, so they are stable for the whole cycle.
- Minimum latency from gnt to inst_valid is 2 cycles: gnt in cycle N, rvalid in N+1, inst_valid in N+2.
- Zero-wait-state throughput is one instruction every 3 cycles: FETCH, then WAIT, then HOLD accepted.
- Redirect to the first request for the new target:
  - 1 cycle from FETCH, WAIT-with-rvalid or HOLD;
  - from WAIT without rvalid, 1 cycle after the stale rvalid.
- Reset asserted mid-transaction abandons any outstanding request. Memory is required to drop it too; there is no drain.

## Structure
- Shared package core_pkg holds:
  - the state enum ifetch_state_t {FETCH, WAIT, HOLD, DRAIN, ERR};
  - INST_BYTES=4;
  - the default RESET_PC constant.
- Single module, no sub-module. Next-state/redirect logic and the datapath registers (fetch_pc, inst, inst_pc) live in one file.
- The existing PC register is subsumed by this block.

## Test plan
- Reset release, gnt tied high, rvalid one cycle after gnt, inst_ready=1:
  - imem_addr sequence is 0x0, 0x4, 0x8;
  - inst_pc matches each address;
  - inst_valid pulses every 3rd cycle.
- inst_ready=0 for 5 cycles while in HOLD: inst and inst_pc are unchanged, imem_req=0. Raising ready gives one transfer, then a request to the next PC.
- Redirect to 0x100 in WAIT, with rvalid 3 cycles later carrying 0xDEADBEEF:
  - 0xDEADBEEF is never presented;
  - the next imem_addr is 0x100.
- Redirect to 0x40 in the same cycle as gnt in FETCH: goes to DRAIN. The stale data is dropped and the next request is to 0x40.
- Redirect to 0x102: misalign_err=1 and imem_req=0 forever after. A later redirect to 0x200 is ignored, and reset clears the error.
- Start at fetch_pc=0xFFFF_FFFC (RESET_PC override): the following fetch address is 0x0000_0000.
